// File: rtl/kb_ascii_ctrl.sv
// PS/2 byte-stream sequencer: filters make/break/extended codes, tracks shift,
// drives the ASCII lookup, folds case and queues characters in a FWFT FIFO.
module kb_ascii_ctrl #(
  parameter int W = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_done_tick,
  input  logic [7:0] scan_in,
  output logic [7:0] scan_code,
  input  logic [7:0] ascii_in,
  input  logic       rd,
  output logic [7:0] ascii_out,
  output logic       empty,
  output logic       full,
  output logic       shift_on,
  output logic       overflow,
  output logic       lost
);
  localparam int DEPTH = 2 ** W;

  typedef enum logic [2:0] {IDLE, LOOKUP, BRK, EXT, EXT_BRK} state_t;

  state_t     state;
  logic [7:0] mem [DEPTH];
  logic [W:0] wr_ptr;
  logic [W:0] rd_ptr;
  logic       is_shift;
  logic       push;
  logic       do_push;
  logic       do_pop;
  logic [7:0] push_data;

  assign is_shift  = (scan_in == 8'h12) || (scan_in == 8'h59);
  assign push      = (state == LOOKUP);
  // The lookup returns upper case; fold letters down unless shift is held.
  assign push_data = (!shift_on && (ascii_in >= 8'h41) && (ascii_in <= 8'h5A))
                     ? (ascii_in | 8'h20) : ascii_in;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[W-1:0] == rd_ptr[W-1:0]) && (wr_ptr[W] != rd_ptr[W]);
  assign do_pop    = rd && !empty;
  assign do_push   = push && (!full || do_pop);
  assign ascii_out = empty ? 8'h00 : mem[rd_ptr[W-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      scan_code <= 8'h00;
      shift_on  <= 1'b0;
      lost      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_done_tick) begin
            if (scan_in == 8'hF0) begin
              state <= BRK;
            end else if (scan_in == 8'hE0) begin
              state <= EXT;
            end else if (is_shift) begin
              shift_on <= 1'b1;
            end else begin
              scan_code <= scan_in;
              state     <= LOOKUP;
            end
          end
        end
        LOOKUP: begin
          state <= IDLE;
          if (rx_done_tick) lost <= 1'b1;
        end
        BRK: begin
          if (rx_done_tick) begin
            if (is_shift) shift_on <= 1'b0;
            state <= IDLE;
          end
        end
        EXT: begin
          if (rx_done_tick) state <= (scan_in == 8'hF0) ? EXT_BRK : IDLE;
        end
        EXT_BRK: begin
          if (rx_done_tick) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A push into a full FIFO only succeeds when the same cycle frees a slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !rd) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[W-1:0]] <= push_data;
  end

endmodule

// File: tb/tb_kb_ascii_ctrl.sv
// Bench for kb_ascii_ctrl: directed vector table, hand-written corner cases and
// random byte streams checked against a queue-based keyboard model.
module tb_kb_ascii_ctrl;
  localparam int W     = 2;
  localparam int DEPTH = 2 ** W;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] scan_in = 8'h00;
  logic [7:0] scan_code;
  logic [7:0] ascii_in;
  logic       rd = 1'b0;
  logic [7:0] ascii_out;
  logic       empty, full, shift_on, overflow, lost;

  int checks = 0;
  int errors = 0;

  kb_ascii_ctrl #(.W(W)) dut (
    .clk(clk), .reset_n(reset_n), .rx_done_tick(rx_done_tick), .scan_in(scan_in),
    .scan_code(scan_code), .ascii_in(ascii_in), .rd(rd), .ascii_out(ascii_out),
    .empty(empty), .full(full), .shift_on(shift_on), .overflow(overflow), .lost(lost)
  );

  always #5 clk = ~clk;

  // Stand-in for the scan-code-to-ASCII ROM (upper case, unknown -> '*').
  function automatic logic [7:0] lut(input logic [7:0] c);
    case (c)
      8'h1C: lut = 8'h41; 8'h32: lut = 8'h42; 8'h21: lut = 8'h43; 8'h23: lut = 8'h44;
      8'h24: lut = 8'h45; 8'h2B: lut = 8'h46; 8'h34: lut = 8'h47; 8'h33: lut = 8'h48;
      8'h43: lut = 8'h49; 8'h3B: lut = 8'h4A; 8'h42: lut = 8'h4B; 8'h4B: lut = 8'h4C;
      8'h3A: lut = 8'h4D; 8'h31: lut = 8'h4E; 8'h44: lut = 8'h4F; 8'h4D: lut = 8'h50;
      8'h15: lut = 8'h51; 8'h2D: lut = 8'h52; 8'h1B: lut = 8'h53; 8'h2C: lut = 8'h54;
      8'h3C: lut = 8'h55; 8'h2A: lut = 8'h56; 8'h1D: lut = 8'h57; 8'h22: lut = 8'h58;
      8'h35: lut = 8'h59; 8'h1A: lut = 8'h5A;
      8'h16: lut = 8'h31; 8'h1E: lut = 8'h32; 8'h26: lut = 8'h33; 8'h25: lut = 8'h34;
      8'h2E: lut = 8'h35; 8'h36: lut = 8'h36; 8'h3D: lut = 8'h37; 8'h3E: lut = 8'h38;
      8'h46: lut = 8'h39; 8'h45: lut = 8'h30; 8'h29: lut = 8'h20; 8'h5A: lut = 8'h0D;
      default: lut = 8'h2A;
    endcase
  endfunction

  always_comb ascii_in = lut(scan_code);

  // Reference model: expected character queue plus pending prefix bytes.
  logic [7:0] exp_q[$];
  logic [7:0] prefix[$];
  logic       m_busy, m_shift, m_overflow, m_lost;
  logic [7:0] m_code;

  task automatic model_reset();
    exp_q.delete();
    prefix.delete();
    m_busy = 0; m_shift = 0; m_overflow = 0; m_lost = 0; m_code = 8'h00;
  endtask

  task automatic model_step(input logic t, input logic [7:0] b, input logic r);
    logic [7:0] ch;
    if (r && exp_q.size() > 0) void'(exp_q.pop_front());
    if (m_busy) begin
      ch = lut(m_code);
      if (!m_shift && ch >= 8'h41 && ch <= 8'h5A) ch = ch + 8'h20;
      if (exp_q.size() < DEPTH) exp_q.push_back(ch);
      else m_overflow = 1;
      if (t) m_lost = 1;
      m_busy = 0;
    end else if (t) begin
      if (prefix.size() == 0) begin
        if (b == 8'hF0 || b == 8'hE0) prefix.push_back(b);
        else if (b == 8'h12 || b == 8'h59) m_shift = 1;
        else begin m_busy = 1; m_code = b; end
      end else if (prefix.size() == 1 && prefix[0] == 8'hF0) begin
        if (b == 8'h12 || b == 8'h59) m_shift = 0;
        prefix.delete();
      end else if (prefix.size() == 1 && b == 8'hF0) begin
        prefix.push_back(b);
      end else begin
        prefix.delete();
      end
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual %02h required %02h", name, act, req);
    end
  endtask

  task automatic checkOutput();
    check("model_ascii_out", ascii_out, (exp_q.size() > 0) ? exp_q[0] : 8'h00);
    check("model_empty", {7'b0, empty}, {7'b0, exp_q.size() == 0});
    check("model_full", {7'b0, full}, {7'b0, exp_q.size() == DEPTH});
    check("model_shift", {7'b0, shift_on}, {7'b0, m_shift});
    check("model_overflow", {7'b0, overflow}, {7'b0, m_overflow});
    check("model_lost", {7'b0, lost}, {7'b0, m_lost});
    check("model_scan_code", scan_code, m_code);
  endtask

  // Drive one cycle of inputs, step the model at the edge, check at negedge.
  task automatic applyStimulus(input logic t, input logic [7:0] b, input logic r);
    rx_done_tick = t;
    scan_in      = b;
    rd           = r;
    @(posedge clk);
    model_step(t, b, r);
    @(negedge clk);
    rx_done_tick = 0;
    rd           = 0;
    checkOutput();
  endtask

  typedef struct {
    logic       tick;
    logic [7:0] byte_v;
    logic       rd_v;
    logic [7:0] exp_ascii;
    logic       exp_empty;
    logic       exp_full;
    logic       exp_shift;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic t, input logic [7:0] b, input logic r, input logic [7:0] ea,
                     input logic ee, input logic ef, input logic es);
    vec_t v;
    v.tick = t; v.byte_v = b; v.rd_v = r; v.exp_ascii = ea;
    v.exp_empty = ee; v.exp_full = ef; v.exp_shift = es;
    vecs.push_back(v);
  endtask

  initial begin
    // Make, pop; shift sequence; extended keys; fill past full with a read.
    add(1, 8'h1C, 0, 8'h00, 1, 0, 0); add(0, 8'h00, 0, 8'h61, 0, 0, 0);
    add(0, 8'h00, 1, 8'h00, 1, 0, 0);
    add(1, 8'h12, 0, 8'h00, 1, 0, 1); add(1, 8'h1C, 0, 8'h00, 1, 0, 1);
    add(0, 8'h00, 0, 8'h41, 0, 0, 1); add(1, 8'hF0, 0, 8'h41, 0, 0, 1);
    add(1, 8'h1C, 0, 8'h41, 0, 0, 1); add(1, 8'hF0, 0, 8'h41, 0, 0, 1);
    add(1, 8'h12, 0, 8'h41, 0, 0, 0); add(1, 8'h1C, 0, 8'h41, 0, 0, 0);
    add(0, 8'h00, 0, 8'h41, 0, 0, 0); add(0, 8'h00, 1, 8'h61, 0, 0, 0);
    add(0, 8'h00, 1, 8'h00, 1, 0, 0);
    add(1, 8'hE0, 0, 8'h00, 1, 0, 0); add(1, 8'h75, 0, 8'h00, 1, 0, 0);
    add(1, 8'hE0, 0, 8'h00, 1, 0, 0); add(1, 8'hF0, 0, 8'h00, 1, 0, 0);
    add(1, 8'h75, 0, 8'h00, 1, 0, 0); add(1, 8'h16, 0, 8'h00, 1, 0, 0);
    add(0, 8'h00, 0, 8'h31, 0, 0, 0); add(0, 8'h00, 1, 8'h00, 1, 0, 0);
    add(1, 8'h16, 0, 8'h00, 1, 0, 0); add(0, 8'h00, 0, 8'h31, 0, 0, 0);
    add(1, 8'h1E, 0, 8'h31, 0, 0, 0); add(0, 8'h00, 0, 8'h31, 0, 0, 0);
    add(1, 8'h26, 0, 8'h31, 0, 0, 0); add(0, 8'h00, 0, 8'h31, 0, 0, 0);
    add(1, 8'h25, 0, 8'h31, 0, 0, 0); add(0, 8'h00, 0, 8'h31, 0, 1, 0);
    add(1, 8'h2E, 0, 8'h31, 0, 1, 0); add(0, 8'h00, 0, 8'h31, 0, 1, 0);
    add(1, 8'h36, 0, 8'h31, 0, 1, 0); add(0, 8'h00, 1, 8'h32, 0, 1, 0);
    add(0, 8'h00, 1, 8'h33, 0, 0, 0); add(0, 8'h00, 1, 8'h34, 0, 0, 0);
    add(0, 8'h00, 1, 8'h36, 0, 0, 0); add(0, 8'h00, 1, 8'h00, 1, 0, 0);

    model_reset();
    reset_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    checkOutput();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].tick, vecs[i].byte_v, vecs[i].rd_v);
      check($sformatf("vec%0d_ascii", i), ascii_out, vecs[i].exp_ascii);
      check($sformatf("vec%0d_empty", i), {7'b0, empty}, {7'b0, vecs[i].exp_empty});
      check($sformatf("vec%0d_full", i), {7'b0, full}, {7'b0, vecs[i].exp_full});
      check($sformatf("vec%0d_shift", i), {7'b0, shift_on}, {7'b0, vecs[i].exp_shift});
    end
    check("overflow_sticky", {7'b0, overflow}, 8'h01);

    // Byte arriving during the lookup cycle is lost; unknown code maps to '*'.
    applyStimulus(1, 8'h1C, 0);
    applyStimulus(1, 8'h32, 0);
    applyStimulus(0, 8'h00, 0);
    check("lost_set", {7'b0, lost}, 8'h01);
    check("lost_head", ascii_out, 8'h61);
    applyStimulus(0, 8'h00, 1);
    check("lost_only_one", {7'b0, empty}, 8'h01);
    applyStimulus(1, 8'h07, 0);
    applyStimulus(0, 8'h00, 0);
    check("unknown_code", ascii_out, 8'h2A);
    applyStimulus(0, 8'h00, 1);

    // Random byte streams with random reads.
    for (int n = 0; n < 600; n++) begin
      logic [7:0] b;
      case ($urandom_range(0, 9))
        0: b = 8'hF0;
        1: b = 8'hE0;
        2: b = 8'h12;
        3: b = 8'h59;
        4: b = 8'h1C;
        5: b = 8'h16;
        6: b = 8'h07;
        default: b = 8'($urandom_range(0, 255));
      endcase
      applyStimulus($urandom_range(0, 9) < 4, b, $urandom_range(0, 9) < 3);
    end

    // Reset asserted with two entries queued and a break pending.
    for (int n = 0; n < 6; n++) applyStimulus(0, 8'h00, 1);
    applyStimulus(1, 8'h1C, 0);
    applyStimulus(0, 8'h00, 0);
    applyStimulus(1, 8'h16, 0);
    applyStimulus(0, 8'h00, 0);
    applyStimulus(1, 8'hF0, 0);
    check("pre_reset_full_count", {7'b0, empty}, 8'h00);
    #2 reset_n = 0;
    #1;
    check("rst_empty", {7'b0, empty}, 8'h01);
    check("rst_full", {7'b0, full}, 8'h00);
    check("rst_ascii", ascii_out, 8'h00);
    check("rst_shift", {7'b0, shift_on}, 8'h00);
    check("rst_overflow", {7'b0, overflow}, 8'h00);
    check("rst_lost", {7'b0, lost}, 8'h00);
    check("rst_scan_code", scan_code, 8'h00);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    model_reset();
    applyStimulus(1, 8'h1C, 0);
    applyStimulus(0, 8'h00, 0);
    check("post_reset_make", ascii_out, 8'h61);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kb_ascii_ctrl.md
# kb_ascii_ctrl

Sequencer sitting between the PS/2 receiver and the scan-code-to-ASCII lookup. It filters the PS/2 byte stream (make, break `F0`, extended `E0`), tracks shift state, drives the lookup with each make code, applies case, and queues resulting characters in a small FIFO. The consumer (UART TX, text display) pops characters with a one-cycle read strobe.

## Interface
- `W`, 2: FIFO address width; depth = 2**W entries.
- `clk`  in  1  system clock, all logic rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_done_tick`  in  1  one-cycle strobe: `scan_in` holds a new byte from the PS/2 receiver.
- `scan_in`  in  8  received byte.
- `scan_code`  out  8  registered code driven to the lookup's `scan_code` input.
- `ascii_in`  in  8  combinational lookup result for `scan_code`; unknown codes return `8'h2A`.
- `rd`  in  1  pop strobe from consumer.
- `ascii_out`  out  8  FIFO head (first-word-fall-through); `8'h00` while empty.
- `empty`  out  1  FIFO empty.
- `full`  out  1  FIFO full.
- `shift_on`  out  1  current shift state.
- `overflow`  out  1  sticky: a character was dropped because FIFO full.
- `lost`  out  1  sticky: a byte arrived while in LOOKUP and was dropped.

## Operation
- Reset: state IDLE, `scan_code`=00, pointers 0, `empty`=1, `full`=0, `shift_on`=0, `overflow`=0, `lost`=0, `ascii_out`=00.
- FSM states: IDLE, LOOKUP, BRK, EXT, EXT_BRK. Transitions are taken only on `rx_done_tick` except LOOKUP.
- IDLE + byte `F0` -> BRK; `E0` -> EXT; `12` or `59` -> set `shift_on`, stay IDLE, nothing pushed; any other byte -> latch into `scan_code`, go LOOKUP.
- LOOKUP (exactly one cycle): sample `ascii_in`; if `shift_on`=0 and `ascii_in` in 41..5A, push `ascii_in | 8'h20`, else push `ascii_in` unchanged; return IDLE. `rx_done_tick` in LOOKUP: byte discarded, `lost` set.
- BRK + byte `12` or `59` -> clear `shift_on`; any byte -> IDLE; nothing pushed.
- EXT + `F0` -> EXT_BRK; EXT + any other byte -> IDLE, byte discarded. EXT_BRK + any byte -> IDLE, discarded; extended codes never change shift.
- Typematic repeat (same make code without break) pushes again each time.
- FIFO: circular buffer, W-bit pointers plus wrap bit; `empty` = pointers equal, `full` = addresses equal and wrap bits differ.
- Push when full and `rd`=0: character dropped, `overflow` set. Push and `rd` in same cycle: both performed, including when full (count unchanged) and when empty (push wins, pop ignored).
- `rd` while empty (no simultaneous push): ignored, no pointer change.
- `overflow`, `lost` cleared only by reset.

## Timing
- Byte tick at cycle N in IDLE (ordinary make): `scan_code` valid N+1 (LOOKUP), push at end of N+1, `empty`=0 and `ascii_out` valid at N+2. Latency 2 cycles tick-to-character.
- `shift_on` updates the cycle after its tick; a make code ticked in that next cycle sees the new value.
- Pop: `rd` at cycle M removes head; next entry (or 00 with `empty`=1) visible at M+1.
- `full`/`empty` registered-pointer derived, valid the cycle after the pointer update.
- Reset assertion mid-operation: all state returns to reset values immediately, FIFO contents discarded.

## Test plan
- Reset then tick `1C` -> `scan_code`=1C next cycle, `ascii_out`=61 ('a'), `empty`=0 two cycles after tick; `rd` -> `empty`=1, `ascii_out`=00.
- Ticks `12`, `1C`, `F0`, `1C`, `F0`, `12`, `1C` -> FIFO holds 41, 61; `shift_on` 1 after first byte, 0 after last break; break codes push nothing.
- Ticks `E0`, `75`, `E0`, `F0`, `75`, then `16` -> only 31 ('1') pushed; `shift_on` stays 0.
- Five make codes (`16`,`1E`,`26`,`25`,`2E`) with W=2, no reads -> `full`=1, contents 31,32,33,34, `overflow`=1; then push `36` with simultaneous `rd` when full -> 31 popped, 36 appended, `full` stays 1.
- Tick `1C` then tick `32` on the very next cycle (in LOOKUP) -> only 61 queued, `lost`=1; unknown code `07` -> 2A pushed.
- Assert `reset_n` low while FIFO holds 2 entries and FSM in BRK -> `empty`=1, state IDLE, flags 0; next `1C` yields 61.
